// File: rtl/ble_cmd_decoder.sv
// ble_cmd_decoder: parses SYNC/CMD/DHI/DLO/CHK frames from the BLE UART, updates
// balance-loop configuration registers and returns one ACK/NAK byte per frame.
`default_nettype none

module ble_cmd_decoder #(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_overrun,
  output logic signed [8:0] pitch_kP,
  output logic signed [8:0] pitch_kI,
  output logic signed [8:0] pitch_kD,
  output logic signed [8:0] yaw_kP,
  output logic signed [8:0] yaw_kI,
  output logic signed [8:0] yaw_kD,
  output logic signed [8:0] set_pitch,
  output logic signed [8:0] set_yaw,
  output logic              vector_valid,
  output logic              initialize_mpu,
  output logic              motor_enable
);

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam int         CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_DHI = 3'd2,
    GET_DLO = 3'd3,
    GET_CHK = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   timeout_cnt;
  logic [7:0]         cmd;
  logic               dhi_lsb;
  logic [7:0]         dlo;
  logic [7:0]         chk_acc;
  logic signed [8:0]  shadow_pitch;
  logic signed [8:0]  shadow_yaw;

  logic signed [8:0]  value;
  logic               mapped;
  logic               good;

  // chk_acc carries CMD^DHI^DLO as the frame arrives, so only DHI[0] needs keeping.
  always_comb begin
    value  = {dhi_lsb, dlo};
    mapped = 1'b0;
    case (cmd)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
      8'h10, 8'h11, 8'h12: mapped = 1'b1;
      default:             mapped = 1'b0;
    endcase
    good = mapped && (rx_data == chk_acc);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      timeout_cnt    <= '0;
      cmd            <= '0;
      dhi_lsb        <= 1'b0;
      dlo            <= '0;
      chk_acc        <= '0;
      shadow_pitch   <= '0;
      shadow_yaw     <= '0;
      pitch_kP       <= '0;
      pitch_kI       <= '0;
      pitch_kD       <= '0;
      yaw_kP         <= '0;
      yaw_kI         <= '0;
      yaw_kD         <= '0;
      set_pitch      <= '0;
      set_yaw        <= '0;
      vector_valid   <= 1'b0;
      initialize_mpu <= 1'b0;
      motor_enable   <= 1'b0;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      tx_overrun     <= 1'b0;
    end else begin
      vector_valid   <= 1'b0;
      initialize_mpu <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;

      if (rx_valid) begin
        timeout_cnt <= '0;
        case (state)
          IDLE:    if (rx_data == SYNC_BYTE) state <= GET_CMD;
          GET_CMD: begin cmd <= rx_data; chk_acc <= rx_data; state <= GET_DHI; end
          GET_DHI: begin dhi_lsb <= rx_data[0]; chk_acc <= chk_acc ^ rx_data; state <= GET_DLO; end
          GET_DLO: begin dlo <= rx_data; chk_acc <= chk_acc ^ rx_data; state <= GET_CHK; end
          GET_CHK: begin
            state <= IDLE;
            if (good) begin
              case (cmd)
                8'h00: pitch_kP     <= value;
                8'h01: pitch_kI     <= value;
                8'h02: pitch_kD     <= value;
                8'h03: yaw_kP       <= value;
                8'h04: yaw_kI       <= value;
                8'h05: yaw_kD       <= value;
                8'h06: shadow_pitch <= value;
                8'h07: shadow_yaw   <= value;
                8'h10: initialize_mpu <= 1'b1;
                8'h11: motor_enable <= dlo[0];
                8'h12: begin
                  set_pitch    <= shadow_pitch;
                  set_yaw      <= shadow_yaw;
                  vector_valid <= 1'b1;
                end
                default: ;
              endcase
            end
            // A handshake in this same cycle frees the buffer for the new response.
            if (!tx_valid || tx_ready) begin
              tx_valid <= 1'b1;
              tx_data  <= good ? ACK_BYTE : NAK_BYTE;
            end else begin
              tx_overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timeout_cnt == CNT_LAST) begin
          state       <= IDLE;
          timeout_cnt <= '0;
        end else begin
          timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
